// File: rtl/led_controller.sv
// Bus-mapped LED output peripheral: pattern, blink and (optional) PWM dimming of 8 LEDs.
// Define LED_PWM_EN to build the DUTY register and PWM counter; otherwise LEDs are never dimmed.
module led_controller #(
  parameter int PRESCALE_DIV = 50000,
  parameter int PRESCALE_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        cs,
  input  logic [1:0]  reg_sel,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic [7:0]  led
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE_DIV - 1);

  // True when the blink counter has reached the end of a half-period; a period of 0 acts as 1.
  function automatic logic blink_wrap(input logic [15:0] cnt, input logic [15:0] per);
    logic [15:0] last;
    last = (per == 16'd0) ? 16'd0 : per - 16'd1;
    return cnt == last;
  endfunction

  logic [7:0]            led_data_q, led_data_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [15:0]           blink_per_q, blink_per_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [15:0]           blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic [7:0]            led_q, led_d;
  logic                  wr_en;
  logic                  tick;
  logic                  pwm_on;

`ifdef LED_PWM_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_on = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
`else
  assign pwm_on = 1'b1;
`endif

  assign wr_en = cs & we;
  assign tick  = (presc_q == PRESC_LAST);
  assign led   = led_q;

  always_comb begin
    led_data_d  = led_data_q;
    ctrl_d      = ctrl_q;
    blink_per_d = blink_per_q;
    if (wr_en) begin
      case (reg_sel)
        2'd0:    led_data_d  = in[7:0];
        2'd1:    ctrl_d      = in[1:0];
        2'd2:    blink_per_d = in;
        default: ;
      endcase
    end
  end

`ifdef LED_PWM_EN
  always_comb begin
    duty_d    = duty_q;
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    if (wr_en && reg_sel == 2'd3) duty_d = in[7:0];
  end
`endif

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // A CTRL or BLINK_PER write takes priority over any tick in the same cycle.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (wr_en && reg_sel == 2'd1) begin
      if (!in[0] || !ctrl_q[0]) begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end
    end else if (wr_en && reg_sel == 2'd2) begin
      blink_cnt_d = '0;
    end else if (!ctrl_q[0]) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (tick) begin
      if (blink_wrap(blink_cnt_q, blink_per_q)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    led_d = ({8{phase_q & pwm_on}} & led_data_q) ^ {8{ctrl_q[1]}};
  end

  always_comb begin
    out = 16'h0000;
    if (cs) begin
      case (reg_sel)
        2'd0:    out = {8'h00, led_data_q};
        2'd1:    out = {14'h0000, ctrl_q};
        2'd2:    out = blink_per_q;
`ifdef LED_PWM_EN
        default: out = {8'h00, duty_q};
`else
        default: out = 16'h0000;
`endif
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_data_q  <= 8'h00;
      ctrl_q      <= 2'b00;
      blink_per_q <= 16'd500;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_q       <= 8'h00;
    end else begin
      led_data_q  <= led_data_d;
      ctrl_q      <= ctrl_d;
      blink_per_q <= blink_per_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

`ifdef LED_PWM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q    <= 8'hFF;
      pwm_cnt_q <= 8'h00;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_led_controller.sv
// Randomized bench for led_controller against a cycle-level reference model, plus directed scenarios.
module tb_led_controller;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        cs = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] din = 16'h0000;
  logic [15:0] out;
  logic [7:0]  led;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [7:0]  m_led_data;
  logic [1:0]  m_ctrl;
  logic [15:0] m_per;
  logic [7:0]  m_duty;
  int          m_presc;
  int          m_bcnt;
  logic        m_phase;
  int          m_pwm;
  logic [7:0]  m_led;

  led_controller #(.PRESCALE_DIV(DIV), .PRESCALE_W(4)) dut (
    .clk(clk), .reset(rst), .we(we), .cs(cs), .reg_sel(sel),
    .in(din), .out(out), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] model_out();
    if (!cs) return 16'h0000;
    case (sel)
      2'd0: return {8'h00, m_led_data};
      2'd1: return {14'h0, m_ctrl};
      2'd2: return m_per;
`ifdef LED_PWM_EN
      default: return {8'h00, m_duty};
`else
      default: return 16'h0000;
`endif
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs presented at that edge.
  task automatic model_edge();
    bit   tick;
    bit   pon;
    bit   wr;
    int   half;
    logic [7:0] nled;
    tick = (m_presc == DIV - 1);
`ifdef LED_PWM_EN
    pon = (m_duty == 8'hFF) || (m_pwm < int'(m_duty));
`else
    pon = 1'b1;
`endif
    nled = (m_phase && pon) ? m_led_data : 8'h00;
    if (m_ctrl[1]) nled = ~nled;
    if (rst) begin
      m_led_data = 8'h00; m_ctrl = 2'b00; m_per = 16'd500; m_duty = 8'hFF;
      m_presc = 0; m_bcnt = 0; m_phase = 1'b1; m_pwm = 0; m_led = 8'h00;
      return;
    end
    m_led   = nled;
    m_presc = (m_presc + 1) % DIV;
    m_pwm   = (m_pwm + 1) % 256;
    wr      = cs && we;
    half    = (m_per == 0) ? 1 : int'(m_per);
    if (wr && sel == 2'd1) begin
      if (din[0] == 1'b0 || m_ctrl[0] == 1'b0) begin m_bcnt = 0; m_phase = 1'b1; end
      m_ctrl = din[1:0];
    end else if (wr && sel == 2'd2) begin
      m_bcnt = 0;
    end else if (m_ctrl[0] == 1'b0) begin
      m_bcnt = 0; m_phase = 1'b1;
    end else if (tick) begin
      m_bcnt = m_bcnt + 1;
      if (m_bcnt >= half) begin m_bcnt = 0; m_phase = ~m_phase; end
    end
    if (wr && sel == 2'd0) m_led_data = din[7:0];
    if (wr && sel == 2'd2) m_per = din;
`ifdef LED_PWM_EN
    if (wr && sel == 2'd3) m_duty = din[7:0];
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", {24'h0, led}, {24'h0, m_led});
    chk("out", {16'h0, out}, {16'h0, model_out()});
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    cs = 1'b1; we = 1'b1; sel = a; din = d;
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
    cs = 1'b1; we = 1'b0; sel = a;
    #1;
    chk(tag, {16'h0, out}, {16'h0, exp});
    cs = 1'b0;
  endtask

  task automatic count_led(input int cycles, input logic [7:0] mask, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if ((led & mask) == mask) hits++;
    end
  endtask

  initial begin
    int hits;
    logic [15:0] duty_rst;
`ifdef LED_PWM_EN
    duty_rst = 16'h00FF;
`else
    duty_rst = 16'h0000;
`endif

    // Reset and reset-value readback
    rst = 1'b1; step(); step(); rst = 1'b0;
    chk("led_after_reset", {24'h0, led}, 32'h0);
    rd_chk("rst_led_data", 2'd0, 16'h0000);
    rd_chk("rst_ctrl", 2'd1, 16'h0000);
    rd_chk("rst_blink_per", 2'd2, 16'd500);
    rd_chk("rst_duty", 2'd3, duty_rst);

    // Plain LED_DATA write, upper bits ignored
    wr_reg(2'd0, 16'hFFA5);
    rd_chk("led_data_rd", 2'd0, 16'h00A5);
    step(); step();
    chk("led_a5", {24'h0, led}, 32'hA5);
    cs = 1'b0; sel = 2'd0; #1;
    chk("cs0_out", {16'h0, out}, 32'h0);

    // Blink with 2-tick half period: 8 clk on, 8 clk off
    wr_reg(2'd0, 16'h00FF);
    wr_reg(2'd2, 16'd2);
    wr_reg(2'd1, 16'd1);
    count_led(32, 8'hFF, hits);
    chk("blink_duty_32", hits, 16);
    wr_reg(2'd1, 16'd0);
    count_led(8, 8'hFF, hits);
    chk("blink_off_steady", hits, 8);

    // BLINK_PER=0 behaves as 1: toggle every tick
    wr_reg(2'd2, 16'd0);
    wr_reg(2'd1, 16'd1);
    count_led(16, 8'hFF, hits);
    chk("per0_toggle", hits, 8);
    for (int i = 0; i < 2 * DIV && m_presc != DIV - 1; i++) step();
    wr_reg(2'd1, 16'd0);
    step();
    count_led(8, 8'hFF, hits);
    chk("ctrl_clear_on_tick", hits, 8);

    // Invert, then reset mid-operation
    wr_reg(2'd1, 16'd2);
    wr_reg(2'd0, 16'h000F);
    step();
    chk("invert_f0", {24'h0, led}, 32'hF0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("led_reset_mid", {24'h0, led}, 32'h0);
    rd_chk("rst2_led_data", 2'd0, 16'h0000);
    rd_chk("rst2_ctrl", 2'd1, 16'h0000);
    rd_chk("rst2_blink_per", 2'd2, 16'd500);
    rd_chk("rst2_duty", 2'd3, duty_rst);

    wr_reg(2'd0, 16'h0001);
`ifdef LED_PWM_EN
    wr_reg(2'd3, 16'd64);
    step();
    count_led(256, 8'h01, hits);
    chk("pwm_64", hits, 64);
    wr_reg(2'd3, 16'd0);
    step();
    count_led(256, 8'h01, hits);
    chk("pwm_0", hits, 0);
    wr_reg(2'd3, 16'd255);
    step();
    count_led(256, 8'h01, hits);
    chk("pwm_255", hits, 256);
`else
    wr_reg(2'd3, 16'h0040);
    rd_chk("no_duty_rd", 2'd3, 16'h0000);
    count_led(64, 8'h01, hits);
    chk("no_pwm_steady", hits, 64);
`endif

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      cs  = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 7) == 0);
      sel = 2'($urandom_range(0, 3));
      case (sel)
        2'd1:    din = 16'($urandom_range(0, 3)) | (16'($urandom) & 16'hFFF0);
        2'd2:    din = 16'($urandom_range(0, 5));
        default: din = 16'($urandom);
      endcase
      step();
    end
    rst = 1'b0; cs = 1'b0; we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
